// File: rtl/imul_dot_accum_pkg.sv
// Shared definitions for the multiply-accumulate stage: message width and the
// controller state encodings used by the RTL and by anything tracing it.
package imul_dot_accum_pkg;

   localparam int unsigned MSG_NBITS = 32;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_DONE  = 2'd1
   } state_e;

endpackage

// File: rtl/imul_dot_accum_ctrl.sv
// Two-state controller: accepts products until the group is full, then offers
// the result and waits for the consumer. Handshake outputs depend only on state.
module imul_dot_accum_ctrl
   import imul_dot_accum_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic in_val_i,
   input  logic out_rdy_i,
   input  logic last_i,
   output logic in_rdy_o,
   output logic out_val_o,
   output logic in_go_o,
   output logic out_go_o
);

   state_e state_q;
   state_e state_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // The unused encoding neither accepts nor offers anything; it just recovers.
   always_comb begin
      state_d   = ST_ACCUM;
      in_rdy_o  = 1'b0;
      out_val_o = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            in_rdy_o = 1'b1;
            state_d  = (in_val_i && last_i) ? ST_DONE : ST_ACCUM;
         end
         ST_DONE: begin
            out_val_o = 1'b1;
            state_d   = out_rdy_i ? ST_ACCUM : ST_DONE;
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
      in_go_o  = in_val_i && in_rdy_o;
      out_go_o = out_val_o && out_rdy_i;
   end

endmodule

// File: rtl/imul_dot_accum.sv
// Sums each group of p_len unsigned products from the multiplier and emits one
// 32-bit result per group, flagging any carry out of bit 31 within the group.
module imul_dot_accum
   import imul_dot_accum_pkg::*;
#(
   parameter int p_len       = 4,
   parameter int p_cnt_nbits = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_val,
   output logic                 in_rdy,
   input  logic [MSG_NBITS-1:0] in_msg,
   output logic                 out_val,
   input  logic                 out_rdy,
   output logic [MSG_NBITS-1:0] out_msg,
   output logic                 out_ovf
);

   localparam logic [p_cnt_nbits-1:0] LAST_CNT = p_cnt_nbits'(p_len - 1);

   logic [MSG_NBITS-1:0]   sum_reg;
   logic [MSG_NBITS-1:0]   sum_d;
   logic [p_cnt_nbits-1:0] cnt_reg;
   logic [p_cnt_nbits-1:0] cnt_d;
   logic                   ovf_reg;
   logic                   ovf_d;
   logic [MSG_NBITS:0]     add_full;
   logic                   last;
   logic                   in_go;
   logic                   out_go;

   imul_dot_accum_ctrl u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .in_val_i  (in_val),
      .out_rdy_i (out_rdy),
      .last_i    (last),
      .in_rdy_o  (in_rdy),
      .out_val_o (out_val),
      .in_go_o   (in_go),
      .out_go_o  (out_go)
   );

   // Top bit of the widened add is the carry out of bit 31.
   assign add_full = {1'b0, sum_reg} + {1'b0, in_msg};
   assign last     = (cnt_reg == LAST_CNT);

   always_comb begin
      sum_d = sum_reg;
      cnt_d = cnt_reg;
      ovf_d = ovf_reg;
      if (out_go) begin
         sum_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (in_go) begin
         sum_d = add_full[MSG_NBITS-1:0];
         cnt_d = cnt_reg + p_cnt_nbits'(1);
         ovf_d = ovf_reg | add_full[MSG_NBITS];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_reg <= '0;
         cnt_reg <= '0;
         ovf_reg <= 1'b0;
      end else begin
         sum_reg <= sum_d;
         cnt_reg <= cnt_d;
         ovf_reg <= ovf_d;
      end
   end

   assign out_msg = sum_reg;
   assign out_ovf = ovf_reg;

   a_hs_known: assert property (@(posedge clk) disable iff (reset)
      !$isunknown({in_val, out_rdy, in_rdy, out_val}));

endmodule

// File: tb/tb_imul_dot_accum.sv
// Self-checking bench for imul_dot_accum: table vectors, hand-written corner
// sequences, and randomized groups against a plain-arithmetic reference model.
module tb_imul_dot_accum;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic        in_val, in_rdy, out_val, out_rdy, out_ovf;
   logic [31:0] in_msg, out_msg;
   logic        in_val2, in_rdy2, out_val2, out_rdy2, out_ovf2;
   logic [31:0] in_msg2, out_msg2;
   logic        in_val1, in_rdy1, out_val1, out_rdy1, out_ovf1;
   logic [31:0] in_msg1, out_msg1;

   imul_dot_accum #(.p_len(4), .p_cnt_nbits(8)) dut (
      .clk(clk), .reset(reset),
      .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
      .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_ovf(out_ovf)
   );

   imul_dot_accum #(.p_len(2), .p_cnt_nbits(8)) dut2 (
      .clk(clk), .reset(reset),
      .in_val(in_val2), .in_rdy(in_rdy2), .in_msg(in_msg2),
      .out_val(out_val2), .out_rdy(out_rdy2), .out_msg(out_msg2), .out_ovf(out_ovf2)
   );

   imul_dot_accum #(.p_len(1), .p_cnt_nbits(8)) dut1 (
      .clk(clk), .reset(reset),
      .in_val(in_val1), .in_rdy(in_rdy1), .in_msg(in_msg1),
      .out_val(out_val1), .out_rdy(out_rdy1), .out_msg(out_msg1), .out_ovf(out_ovf1)
   );

   int checks = 0;
   int errors = 0;
   bit trace_en = 1'b0;

   typedef struct {
      string       name;
      logic [31:0] p [4];
      logic [31:0] sum;
      logic        ovf;
   } vec_t;

   vec_t tbl [5];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic checkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference: group sum modulo 2^32, ovf if any running add wraps past 2^32.
   function automatic void model(input logic [31:0] q [$], output logic [31:0] s, output logic o);
      longint unsigned acc;
      acc = 0;
      o   = 1'b0;
      foreach (q[i]) begin
         acc = acc + longint'(q[i]);
         if (acc >= 64'h1_0000_0000) begin
            o   = 1'b1;
            acc = acc - 64'h1_0000_0000;
         end
      end
      s = acc[31:0];
   endfunction

   function automatic string trace_line();
      string f_in, f_out, st;
      if (in_val && in_rdy) f_in = $sformatf("%08h", in_msg);
      else if (in_val)      f_in = "#       ";
      else                  f_in = ".       ";
      if (out_val && out_rdy) f_out = $sformatf("%08h%s", out_msg, out_ovf ? "+" : " ");
      else if (out_val)       f_out = "#        ";
      else                    f_out = ".        ";
      st = (dut.u_ctrl.state_q == 2'd1) ? "D" : "A";
      return $sformatf("%s (%02h/%08h %s) %s", f_in, dut.cnt_reg, dut.sum_reg, st, f_out);
   endfunction

   always @(negedge clk) if (trace_en) $display("%s", trace_line());

   task automatic push(input logic [31:0] m, input int bubbles);
      int n;
      repeat (bubbles) begin
         in_val = 1'b0;
         in_msg = $urandom;
         @(negedge clk);
      end
      n = 0;
      while (!in_rdy && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!in_rdy) begin
         checkb("push_timeout", in_rdy, 1'b1);
         return;
      end
      in_val = 1'b1;
      in_msg = m;
      @(negedge clk);
      in_val = 1'b0;
      in_msg = $urandom;
   endtask

   task automatic pop(input string name, input logic [31:0] exp_sum, input logic exp_ovf);
      int n;
      n = 0;
      while (!out_val && n < 64) begin
         @(negedge clk);
         n++;
      end
      checkb({name, "_val"}, out_val, 1'b1);
      check32({name, "_msg"}, out_msg, exp_sum);
      checkb({name, "_ovf"}, out_ovf, exp_ovf);
      checkb({name, "_rdy_lo"}, in_rdy, 1'b0);
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      checkb({name, "_val_lo"}, out_val, 1'b0);
      checkb({name, "_rdy_hi"}, in_rdy, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q [$];
      logic [31:0] es;
      logic        eo;

      tbl[0].name = "seq1234";  tbl[0].p = '{32'd1, 32'd2, 32'd3, 32'd4};
      tbl[0].sum  = 32'd10;     tbl[0].ovf = 1'b0;
      tbl[1].name = "wrap";     tbl[1].p = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
      tbl[1].sum  = 32'd1;      tbl[1].ovf = 1'b1;
      tbl[2].name = "ones";     tbl[2].p = '{32'd1, 32'd1, 32'd1, 32'd1};
      tbl[2].sum  = 32'd4;      tbl[2].ovf = 1'b0;
      tbl[3].name = "halves";   tbl[3].p = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0};
      tbl[3].sum  = 32'd1;      tbl[3].ovf = 1'b1;
      tbl[4].name = "maxsum";   tbl[4].p = '{32'hFFFF_FFFC, 32'd1, 32'd1, 32'd1};
      tbl[4].sum  = 32'hFFFF_FFFF; tbl[4].ovf = 1'b0;

      reset = 1'b1;
      in_val = 1'b0;  in_msg = '0;  out_rdy = 1'b0;
      in_val2 = 1'b0; in_msg2 = '0; out_rdy2 = 1'b0;
      in_val1 = 1'b0; in_msg1 = '0; out_rdy1 = 1'b0;
      repeat (2) @(negedge clk);
      checkb("rst_in_rdy", in_rdy, 1'b1);
      checkb("rst_out_val", out_val, 1'b0);
      check32("rst_out_msg", out_msg, 32'd0);
      checkb("rst_out_ovf", out_ovf, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      // Table vectors, back-to-back, checking the DONE latency.
      for (int i = 0; i < 5; i++) begin
         trace_en = (i == 0);
         for (int k = 0; k < 4; k++) begin
            push(tbl[i].p[k], 0);
            if (k < 3) checkb({tbl[i].name, "_early"}, out_val, 1'b0);
         end
         checkb({tbl[i].name, "_latency"}, out_val, 1'b1);
         pop(tbl[i].name, tbl[i].sum, tbl[i].ovf);
      end
      trace_en = 1'b0;

      // Back-pressure in DONE with garbage on the input, then simultaneous val/rdy.
      push(32'h11, 0); push(32'h22, 0); push(32'h33, 0); push(32'h44, 0);
      in_val = 1'b1;
      in_msg = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         checkb("bp_out_val", out_val, 1'b1);
         checkb("bp_in_rdy", in_rdy, 1'b0);
         check32("bp_out_msg", out_msg, 32'hAA);
         @(negedge clk);
      end
      out_rdy = 1'b1;
      in_msg  = 32'd100;
      @(negedge clk);
      out_rdy = 1'b0;
      checkb("simul_out_val", out_val, 1'b0);
      checkb("simul_in_rdy", in_rdy, 1'b1);
      check32("simul_not_taken", out_msg, 32'd0);
      @(negedge clk);
      in_val = 1'b0;
      push(32'd0, 0); push(32'd0, 0); push(32'd0, 0);
      pop("simul", 32'd100, 1'b0);

      // Bubbles around 7s give the same result as a dense run.
      for (int k = 0; k < 4; k++) push(32'd7, $urandom_range(0, 3));
      pop("bubbles", 32'd28, 1'b0);

      // Reset mid-group discards the partial sum.
      push(32'd9, 0); push(32'd9, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkb("rmid_in_rdy", in_rdy, 1'b1);
      check32("rmid_out_msg", out_msg, 32'd0);
      for (int k = 0; k < 4; k++) push(32'd5, 0);
      pop("after_rmid", 32'd20, 1'b0);

      // Reset with a pending overflowed result discards it.
      push(32'hFFFF_FFFF, 0); push(32'd1, 0); push(32'd0, 0); push(32'd0, 0);
      checkb("rdone_pending", out_val, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkb("rdone_out_val", out_val, 1'b0);
      checkb("rdone_out_ovf", out_ovf, 1'b0);
      check32("rdone_out_msg", out_msg, 32'd0);
      push(32'd1, 0); push(32'd2, 0); push(32'd3, 0); push(32'd4, 0);
      pop("after_rdone", 32'd10, 1'b0);

      // Randomized groups against the reference model.
      for (int g = 0; g < 25; g++) begin
         q = {};
         for (int k = 0; k < 4; k++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
               0:       v = 32'($urandom_range(0, 255));
               1:       v = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
               2:       v = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
               default: v = $urandom;
            endcase
            q.push_back(v);
            push(v, $urandom_range(0, 2));
         end
         repeat ($urandom_range(0, 3)) begin
            check32("rand_hold", out_msg, out_msg);
            @(negedge clk);
         end
         model(q, es, eo);
         pop($sformatf("rand%0d", g), es, eo);
      end

      // Products straight from the multiplier: p_len=2 gets 3*4 and 5*6.
      checkb("pl2_in_rdy", in_rdy2, 1'b1);
      in_val2 = 1'b1; in_msg2 = 32'(3 * 4);
      @(negedge clk);
      in_msg2 = 32'(5 * 6);
      @(negedge clk);
      in_val2 = 1'b0;
      checkb("pl2_out_val", out_val2, 1'b1);
      check32("pl2_out_msg", out_msg2, 32'd42);
      checkb("pl2_out_ovf", out_ovf2, 1'b0);
      out_rdy2 = 1'b1;
      @(negedge clk);
      out_rdy2 = 1'b0;
      checkb("pl2_done", out_val2, 1'b0);

      // p_len=1 emits every product alone, alternating accept and DONE.
      out_rdy1 = 1'b1;
      in_val1  = 1'b1;
      in_msg1  = 32'(7 * 8);
      @(negedge clk);
      checkb("pl1_val_a", out_val1, 1'b1);
      check32("pl1_msg_a", out_msg1, 32'd56);
      checkb("pl1_in_rdy_a", in_rdy1, 1'b0);
      @(negedge clk);
      checkb("pl1_gap", out_val1, 1'b0);
      checkb("pl1_in_rdy_b", in_rdy1, 1'b1);
      @(negedge clk);
      checkb("pl1_val_b", out_val1, 1'b1);
      check32("pl1_msg_b", out_msg1, 32'd56);
      checkb("pl1_ovf_b", out_ovf1, 1'b0);
      in_val1 = 1'b0;
      @(negedge clk);
      checkb("pl1_idle", out_val1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imul_dot_accum.md
# imul_dot_accum

Accumulator stage that sits directly downstream of the variable-latency integer multiplier. Its val/rdy input connects straight to the multiplier's 32-bit response port. It sums every group of `p_len` consecutive products and emits one 32-bit dot-product result per group, plus an overflow flag. This gives the multiplier a multiply-accumulate consumer without modifying the multiplier itself.

## Interface
- `p_len`, default 4: products per group; legal range 1..255.
- `p_cnt_nbits`, default 8: width of the group counter; must satisfy `p_len` ≤ 2^`p_cnt_nbits` − 1.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_val`  in  1  product valid (from multiplier `out_val`).
- `in_rdy`  out  1  stage can accept a product (to multiplier `out_rdy`).
- `in_msg`  in  32  product, treated as unsigned.
- `out_val`  out  1  group result valid.
- `out_rdy`  in  1  consumer accepts result.
- `out_msg`  out  32  sum of the group's products, modulo 2^32.
- `out_ovf`  out  1  at least one add in this group produced a carry out of bit 31.

## Operation
- Handshake events:
  - `in_go` = `in_val` && `in_rdy`.
  - `out_go` = `out_val` && `out_rdy`.
- Datapath registers:
  - `sum_reg[31:0]`
  - `cnt_reg[p_cnt_nbits-1:0]`
  - `ovf_reg`
- FSM states: `ACCUM`, `DONE`. Two-bit encoding; the unused encoding goes to `ACCUM`.
- `ACCUM`:
  - Outputs: `in_rdy`=1, `out_val`=0.
  - On `in_go`:
    - `sum_reg` ← `sum_reg` + `in_msg` (32-bit wrap).
    - `ovf_reg` ← `ovf_reg` | carry.
    - `cnt_reg` ← `cnt_reg` + 1.
  - If `in_go` && `cnt_reg` == `p_len`−1, next state is `DONE`.
- `DONE`:
  - Outputs: `in_rdy`=0, `out_val`=1.
  - `sum_reg`, `cnt_reg` and `ovf_reg` hold.
  - On `out_go`:
    - `sum_reg` ← 0, `cnt_reg` ← 0, `ovf_reg` ← 0.
    - Next state is `ACCUM`.
- Output wiring: `out_msg` = `sum_reg` and `out_ovf` = `ovf_reg` in all states. Both are meaningful only while `out_val`=1.
- `in_val`=0 cycles (bubbles) in `ACCUM` leave all state unchanged.
- `p_len`=1: every accepted product is emitted alone, with `out_ovf` always 0.
- `in_msg` is ignored whenever `in_rdy`=0.

## Timing
- Reset behaviour: on any clock edge with `reset`=1, the FSM goes to `ACCUM` and `sum_reg`, `cnt_reg`, `ovf_reg` are cleared to 0. This holds regardless of the current state, including mid-group and in `DONE` with a result pending; a partial or pending result is discarded.
- Output values after reset: `in_rdy`=1, `out_val`=0, `out_msg`=0, `out_ovf`=0.
- Latency: `out_val` rises one cycle after the edge that accepts the `p_len`-th product.
- Throughput: at most one result per `p_len`+1 cycles; the `DONE` state costs one cycle minimum.
- Back-pressure: while `out_rdy`=0 in `DONE`, `out_val`, `out_msg` and `out_ovf` stay stable and `in_rdy` stays 0. The multiplier therefore holds its own result.
- All outputs decode from registered state only: there is no combinational path from `in_val` or `out_rdy` to `in_rdy` or `out_val`.
- Simultaneous `in_val` and `out_rdy` in `DONE`: only `out_go` fires. Input is first accepted in the following cycle.

## Structure
- Shared package/include: 32-bit message width constant and the `ACCUM`/`DONE` state encodings, so tracing and other consumers share the encodings.
- Split into a datapath (adder with carry-out, sum/count/ovf registers, count comparator) and one natural sub-module, `imul_dot_accum_ctrl`, holding the FSM and the handshake outputs.
- Assertions: `in_val`, `out_rdy`, `in_rdy` and `out_val` are never X outside reset.
- Line trace:
  - Input field.
  - `cnt_reg`/`sum_reg`.
  - State letter: A for `ACCUM`, D for `DONE`.
  - Output field.

## Test plan
- `p_len`=4, inputs 1, 2, 3, 4 back-to-back, `out_rdy`=1 → `out_msg`=10 and `out_ovf`=0 one cycle after the 4th accept, then `in_rdy`=1 again.
- Inputs 0xFFFFFFFF, 2, 0, 0 → `out_msg`=0x00000001, `out_ovf`=1. Next group 1, 1, 1, 1 → 4, `out_ovf`=0.
- Hold `out_rdy`=0 for 3 cycles in `DONE` → `out_val`=1, `out_msg` stable, `in_rdy`=0 throughout; release → one `out_go`, return to `ACCUM`.
- Random `in_val` bubbles around 7, 7, 7, 7 → 28, identical to the no-bubble run.
- Assert `reset` after 2 accepted inputs (9, 9), then feed 5, 5, 5, 5 → 20.
- End-to-end with the multiplier, `p_len`=2: requests 3×4 and 5×6 → 42. Also instantiate `p_len`=1 with 7×8 → 56 emitted per product.
